// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite position engine.
package sprite_pkg;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } vstate_t;

    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    // Either jump key starts a jump from the ground.
    function automatic logic is_jump_key(input logic [7:0] k);
        return (k == KEY_SPACE) || (k == KEY_W);
    endfunction

endpackage

// File: rtl/sprite_motion_if.sv
// Keyboard/vsync inputs and sprite position outputs between the SoC side and the engine.
interface sprite_motion_if;
    logic       frame_clk;
    logic [7:0] keycode;
    logic [9:0] SpriteX;
    logic [9:0] SpriteY;
    logic       facing_left;
    logic       airborne;
    logic       frame_tick;

    modport master (
        output frame_clk, keycode,
        input  SpriteX, SpriteY, facing_left, airborne, frame_tick
    );

    modport slave (
        input  frame_clk, keycode,
        output SpriteX, SpriteY, facing_left, airborne, frame_tick
    );
endinterface

// File: rtl/sprite_motion_frame_tick_sync.sv
// Brings the vsync strobe into the Clk domain and emits one pulse per rising edge.
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic async_in,
    output logic tick_out
);
    // sync_q[1:0] is the 2-FF synchronizer, sync_q[2] holds the previous synced value
    logic [2:0] sync_q, sync_d;
    logic       tick_q, tick_d;

    // Shift the input through the chain and detect a 0->1 transition
    always_comb begin
        sync_d = {sync_q[1:0], async_in};
        tick_d = sync_q[1] & ~sync_q[2];
    end

    // Register the chain and the tick; idle-high so reset never fakes an edge
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync_q <= 3'b111;
            tick_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            tick_q <= tick_d;
        end
    end

    assign tick_out = tick_q;
endmodule

// File: rtl/sprite_motion.sv
// Per-frame sprite position engine: walking with wall clamps plus a gravity jump FSM.
module sprite_motion
    import sprite_pkg::*;
#(
    parameter int X_START  = 320,
    parameter int Y_GROUND = 400,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 575,
    parameter int Y_MIN    = 0,
    parameter int STEP     = 2,
    parameter int JUMP_V   = 12,
    parameter int GRAVITY  = 1,
    parameter int VMAX     = 15
) (
    input  logic            Clk,
    input  logic            Reset,
    sprite_motion_if.slave  bus
);
    localparam logic [9:0] X_START10  = 10'(X_START);
    localparam logic [9:0] Y_GROUND10 = 10'(Y_GROUND);
    localparam logic [9:0] X_MIN10    = 10'(X_MIN);
    localparam logic [9:0] X_MAX10    = 10'(X_MAX);
    localparam logic [9:0] Y_MIN10    = 10'(Y_MIN);
    localparam logic [9:0] STEP10     = 10'(STEP);
    localparam logic [4:0] JUMP_V5    = 5'(JUMP_V);
    localparam logic [4:0] GRAV5      = 5'(GRAVITY);
    localparam logic [4:0] VMAX5      = 5'(VMAX);

    logic tick;

    frame_tick_sync u_tick (
        .Clk      (Clk),
        .Reset    (Reset),
        .async_in (bus.frame_clk),
        .tick_out (tick)
    );

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic [4:0] vy_q, vy_d;
    vstate_t    state_q, state_d;
    logic       facing_left_q, facing_left_d;
    logic       airborne_q, airborne_d;

    // Intermediate arithmetic; widened where an over/underflow must be caught
    logic [9:0]  x_left;
    logic [10:0] x_right;
    logic [9:0]  y_up;
    logic [4:0]  vy_dec;
    logic [5:0]  vy_inc;
    logic [4:0]  vn;
    logic [10:0] y_down;

    // Next-state: everything holds except on the frame tick
    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        vy_d          = vy_q;
        state_d       = state_q;
        facing_left_d = facing_left_q;
        airborne_d    = airborne_q;

        x_left  = x_q - STEP10;
        x_right = {1'b0, x_q} + {1'b0, STEP10};
        y_up    = y_q - {5'b0, vy_q};
        vy_dec  = vy_q - GRAV5;
        vy_inc  = {1'b0, vy_q} + {1'b0, GRAV5};
        vn      = (vy_inc > {1'b0, VMAX5}) ? VMAX5 : vy_inc[4:0];
        y_down  = {1'b0, y_q} + {6'b0, vn};

        if (tick) begin
            // Horizontal walk, independent of the vertical state
            if (bus.keycode == KEY_A) begin
                facing_left_d = 1'b1;
                if ({1'b0, x_q} < ({1'b0, X_MIN10} + {1'b0, STEP10}))
                    x_d = X_MIN10;
                else
                    x_d = x_left;
            end else if (bus.keycode == KEY_D) begin
                facing_left_d = 1'b0;
                if (x_right > {1'b0, X_MAX10})
                    x_d = X_MAX10;
                else
                    x_d = x_right[9:0];
            end

            // Vertical FSM; vy is a magnitude, direction comes from the state
            case (state_q)
                GROUND: begin
                    if (is_jump_key(bus.keycode)) begin
                        state_d = RISE;
                        vy_d    = JUMP_V5;
                    end else begin
                        y_d = Y_GROUND10;
                    end
                end
                RISE: begin
                    if ({1'b0, y_q} < ({6'b0, vy_q} + {1'b0, Y_MIN10})) begin
                        // Would pass the top edge: pin to the ceiling and start falling
                        y_d     = Y_MIN10;
                        vy_d    = 5'd0;
                        state_d = FALL;
                    end else begin
                        y_d  = y_up;
                        vy_d = vy_dec;
                        if (vy_dec == 5'd0)
                            state_d = FALL;
                    end
                end
                FALL: begin
                    if (y_down >= {1'b0, Y_GROUND10}) begin
                        y_d     = Y_GROUND10;
                        vy_d    = 5'd0;
                        state_d = GROUND;
                    end else begin
                        y_d  = y_down[9:0];
                        vy_d = vn;
                    end
                end
                default: begin
                    state_d = GROUND;
                    vy_d    = 5'd0;
                    y_d     = Y_GROUND10;
                end
            endcase

            airborne_d = (state_d != GROUND);
        end
    end

    // Position/FSM registers; reset lands the sprite at its start point immediately
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            x_q           <= X_START10;
            y_q           <= Y_GROUND10;
            vy_q          <= 5'd0;
            state_q       <= GROUND;
            facing_left_q <= 1'b0;
            airborne_q    <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            vy_q          <= vy_d;
            state_q       <= state_d;
            facing_left_q <= facing_left_d;
            airborne_q    <= airborne_d;
        end
    end

    assign bus.SpriteX     = x_q;
    assign bus.SpriteY     = y_q;
    assign bus.facing_left = facing_left_q;
    assign bus.airborne    = airborne_q;
    assign bus.frame_tick  = tick;
endmodule

// File: doc/sprite_motion.md
Name: sprite_motion

Overview:
- Per-frame sprite position engine, directly upstream of the sprite drawing stage.
- Consumes the USB keycode from the SoC PIO and the VGA vertical sync as a frame strobe.
- Produces SpriteX/SpriteY for the drawing stage: horizontal walking with wall clamping, plus a gravity-driven jump state machine.
- Runs entirely in the 50 MHz domain.

Parameters:
- X_START, 320, reset X position (pixels, left edge of sprite).
- Y_GROUND, 400, ground Y position and reset Y position.
- X_MIN, 0, leftmost legal X.
- X_MAX, 575, rightmost legal X (640 minus 64-pixel sprite width, minus 1).
- Y_MIN, 0, topmost legal Y.
- STEP, 2, horizontal pixels moved per frame.
- JUMP_V, 12, initial upward velocity (pixels/frame).
- GRAVITY, 1, velocity change per frame.
- VMAX, 15, terminal fall velocity.

Ports:
- Clk, in, 1, 50 MHz system clock.
- Reset, in, 1, asynchronous active-high reset.
- frame_clk, in, 1, VGA_VS (active-low vsync); asynchronous to Clk sampling.
- keycode, in, 8, current USB HID keycode; 0x00 = no key.
- SpriteX, out, 10, sprite left-edge X.
- SpriteY, out, 10, sprite top-edge Y.
- facing_left, out, 1, 1 = last horizontal move was left.
- airborne, out, 1, 1 while in RISE or FALL.
- frame_tick, out, 1, one-Clk pulse marking each position update.

Behaviour:
- Reset: SpriteX = X_START, SpriteY = Y_GROUND, vy = 0, state = GROUND, facing_left = 0, airborne = 0, frame_tick = 0, synchronizer flops = 1.
- Reset asserted mid-jump returns all state to these values immediately.
- Frame tick generation:
  - frame_clk passes through a 2-FF synchronizer, then a rising-edge detect (end of vsync pulse).
  - frame_tick is high for exactly one Clk cycle, 3 Clk cycles after the frame_clk rise.
  - A frame_clk held static produces no ticks.
- All state updates occur only on the frame_tick cycle; keycode is sampled only then. Outputs are registered and change on the Clk edge after frame_tick.
- Horizontal motion (any vertical state):
  - keycode 0x04 (A): X -= STEP, clamped to X_MIN; facing_left = 1.
  - keycode 0x07 (D): X += STEP, clamped to X_MAX; facing_left = 0.
  - Any other code: X and facing_left unchanged.
  - Compute in 11 bits so that underflow below X_MIN clamps instead of wrapping.
- Vertical FSM, state GROUND:
  - keycode 0x2C (space) or 0x1A (W) on a tick: go to RISE, vy = JUMP_V. Y is unchanged on this tick.
  - Otherwise Y = Y_GROUND.
- Vertical FSM, state RISE:
  - Y = Y - vy, vy = vy - GRAVITY.
  - If the new vy is 0: go to FALL.
  - If Y - vy < Y_MIN (11-bit compare): Y = Y_MIN, vy = 0, go to FALL.
- Vertical FSM, state FALL:
  - vn = min(vy + GRAVITY, VMAX); Yn = Y + vn.
  - If Yn >= Y_GROUND: Y = Y_GROUND, vy = 0, go to GROUND.
  - Otherwise Y = Yn, vy = vn.
- Jump keys held while airborne are ignored; no double jump.
- airborne = (state != GROUND), registered with the state.
- vy is a 5-bit unsigned magnitude; direction is implied by state.

Decomposition:
- sprite_pkg holds:
  - typedef enum {GROUND, RISE, FALL} vstate_t;
  - keycode constants KEY_A = 8'h04, KEY_D = 8'h07, KEY_W = 8'h1A, KEY_SPACE = 8'h2C.
- One sub-module, frame_tick_sync: 2-FF synchronizer plus rising-edge detect, with Clk, Reset, async_in and tick_out.

Test Plan:
- Reset, then 10 frame_clk rises with keycode = 0x00: SpriteX = 320, SpriteY = 400, airborne = 0, exactly 10 frame_tick pulses, each 3 Clk cycles after its frame_clk rise.
- keycode = 0x07 held for 200 frames from X = 320: X rises by 2 per frame, reaches 575 at frame 128 and stays at 575; facing_left = 0.
- keycode = 0x04 held for 200 frames from X = 320: X reaches 0 at frame 160 and stays at 0 (no wrap to 1023); facing_left = 1.
- keycode = 0x2C for one frame, then 0x00:
  - Tick 1: RISE, Y = 400.
  - After 12 more ticks: Y = 322, state FALL.
  - After 12 further ticks: Y = 400, GROUND, airborne = 0.
  - Total airborne span is 25 ticks.
- keycode = 0x2C held continuously: after landing at tick 25, tick 26 starts a new jump; no re-trigger occurs while airborne.
- Reset asserted at RISE tick 5, between Clk edges: outputs return to X = 320, Y = 400, GROUND asynchronously, without waiting for a clock edge.
